// File: rtl/as_pack.sv
// as_pack: shared register-file widths, types and constants for the decode/writeback stage
package as_pack;
  localparam int reg_width = 32;
  localparam int nr_regs = 32;
  localparam int rwaddr_width = 5;
  typedef logic [rwaddr_width-1:0] rf_addr_t;
  typedef logic [reg_width-1:0] rf_data_t;
  localparam rf_addr_t RF_ZERO_ADDR = '0;
endpackage

// File: rtl/as_rf_scoreboard.sv
// as_rf_scoreboard: per-register busy bits with issue/clear/flush and per-read-port lookup
// AS_RF_BYPASS_EN: a same-cycle clearing write also drops rbusy_o for the matching read port
module as_rf_scoreboard #(
  parameter int NR_RD = 2,
  parameter int NR_WR = 1,
  parameter int NREG = 32,
  parameter int AW = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NR_RD-1:0][AW-1:0]  raddr_i,
  input  logic [NR_WR-1:0]          we_i,
  input  logic [NR_WR-1:0][AW-1:0]  waddr_i,
  input  logic [NR_WR-1:0]          wclr_i,
  input  logic                      iss_i,
  input  logic [AW-1:0]             iss_addr_i,
  input  logic                      flush_i,
  output logic [NR_RD-1:0]          rbusy_o,
  output logic [NREG-1:0]           busy_o
);
  logic [NREG-1:0] busy_q, busy_d;
  // Set after clears so a newly issued producer wins; flush overrides everything.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NR_WR; k++)
      if (we_i[k] && wclr_i[k]) busy_d[waddr_i[k]] = 1'b0;
    if (iss_i) busy_d[iss_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush_i) busy_d = '0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_o = busy_q;
  always_comb begin
    for (int j = 0; j < NR_RD; j++) begin
      rbusy_o[j] = busy_q[raddr_i[j]];
`ifdef AS_RF_BYPASS_EN
      for (int k = 0; k < NR_WR; k++)
        if (we_i[k] && wclr_i[k] && waddr_i[k] == raddr_i[j] && !(iss_i && iss_addr_i == raddr_i[j]))
          rbusy_o[j] = 1'b0;
`endif
    end
  end
endmodule

// File: rtl/as_regfile_mp.sv
// as_regfile_mp: multi-port integer register file with busy scoreboard and sticky write-conflict flag
// AS_RF_BYPASS_EN: forwards same-cycle write data to matching read ports
module as_regfile_mp
  import as_pack::*;
#(
  parameter int NR_RD = 2,
  parameter int NR_WR = 1,
  parameter int DW = reg_width,
  parameter int NREG = nr_regs,
  parameter int AW = rwaddr_width
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NR_RD-1:0][AW-1:0]  raddr_i,
  output logic [NR_RD-1:0][DW-1:0]  rdata_o,
  output logic [NR_RD-1:0]          rbusy_o,
  input  logic [NR_WR-1:0]          we_i,
  input  logic [NR_WR-1:0][AW-1:0]  waddr_i,
  input  logic [NR_WR-1:0][DW-1:0]  wdata_i,
  input  logic [NR_WR-1:0]          wclr_i,
  input  logic                      iss_i,
  input  logic [AW-1:0]             iss_addr_i,
  input  logic                      flush_i,
  output logic [NREG-1:0]           busy_o,
  output logic                      werr_o
);
  localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_ADDR);
  if (AW != $clog2(NREG)) $error("AW must equal log2(NREG)");
  if (NR_RD < 1 || NR_RD > 4) $error("NR_RD must be 1..4");
  if (NR_WR < 1 || NR_WR > 2) $error("NR_WR must be 1..2");
  logic [NREG-1:0][DW-1:0] mem_q;
  logic werr_q, coll;
  always_comb begin
    coll = 1'b0;
    for (int i = 0; i < NR_WR; i++)
      for (int j = i + 1; j < NR_WR; j++)
        coll = coll | (we_i[i] && we_i[j] && waddr_i[i] == waddr_i[j] && waddr_i[i] != ZERO);
  end
  // Later ports are assigned last, so the highest index wins a collision.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mem_q <= '0;
      werr_q <= 1'b0;
    end else begin
      werr_q <= werr_q | coll;
      for (int k = 0; k < NR_WR; k++)
        if (we_i[k] && waddr_i[k] != ZERO) mem_q[waddr_i[k]] <= wdata_i[k];
    end
  assign werr_o = werr_q;
  always_comb begin
    for (int j = 0; j < NR_RD; j++) begin
      rdata_o[j] = raddr_i[j] == ZERO ? '0 : mem_q[raddr_i[j]];
`ifdef AS_RF_BYPASS_EN
      for (int k = 0; k < NR_WR; k++)
        if (we_i[k] && waddr_i[k] != ZERO && waddr_i[k] == raddr_i[j]) rdata_o[j] = wdata_i[k];
`endif
    end
  end
  as_rf_scoreboard #(.NR_RD(NR_RD), .NR_WR(NR_WR), .NREG(NREG), .AW(AW)) u_sb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .raddr_i(raddr_i),
    .we_i(we_i),
    .waddr_i(waddr_i),
    .wclr_i(wclr_i),
    .iss_i(iss_i),
    .iss_addr_i(iss_addr_i),
    .flush_i(flush_i),
    .rbusy_o(rbusy_o),
    .busy_o(busy_o)
  );
endmodule

// File: tb/tb_as_regfile_mp.sv
// tb_as_regfile_mp: directed table, hand sequences and randomized model checks for as_regfile_mp
module tb_as_regfile_mp;
  localparam int NR_RD = 2, NR_WR = 2, DW = 32, NREG = 32, AW = 5;
  logic clk = 1'b0, rst = 1'b0;
  logic [NR_RD-1:0][AW-1:0] raddr;
  logic [NR_RD-1:0][DW-1:0] rdata;
  logic [NR_RD-1:0] rbusy;
  logic [NR_WR-1:0] we, wclr;
  logic [NR_WR-1:0][AW-1:0] waddr;
  logic [NR_WR-1:0][DW-1:0] wdata;
  logic iss, flush;
  logic [AW-1:0] iss_addr;
  logic [NREG-1:0] busy;
  logic werr;
  int checks = 0, failures = 0;
  logic [31:0] m_reg [NREG];
  bit m_busy [NREG];
  bit m_werr;

  as_regfile_mp #(.NR_RD(NR_RD), .NR_WR(NR_WR), .DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wclr_i(wclr), .iss_i(iss),
    .iss_addr_i(iss_addr), .flush_i(flush), .busy_o(busy), .werr_o(werr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] we; logic [4:0] wa0, wa1; logic [31:0] wd0, wd1; logic [1:0] wclr;
    logic iss; logic [4:0] ia; logic fl; logic [4:0] ra;
    logic [31:0] e_rd; logic e_rb; logic [31:0] e_busy; logic e_werr;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_werr = 1'b0;
  endtask

  task automatic model_edge();
    if (we == 2'b11 && waddr[0] == waddr[1] && waddr[0] != 0) m_werr = 1'b1;
    for (int k = 0; k < NR_WR; k++)
      if (we[k] && waddr[k] != 0) m_reg[waddr[k]] = wdata[k];
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else begin
      for (int k = 0; k < NR_WR; k++)
        if (we[k] && wclr[k]) m_busy[waddr[k]] = 1'b0;
      if (iss && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [AW-1:0] a);
    logic [31:0] v;
    v = a == 0 ? 32'h0 : m_reg[a];
`ifdef AS_RF_BYPASS_EN
    for (int k = 0; k < NR_WR; k++)
      if (we[k] && waddr[k] == a && a != 0) v = wdata[k];
`endif
    return v;
  endfunction

  function automatic logic exp_rbusy(input logic [AW-1:0] a);
    logic v;
    v = m_busy[a];
`ifdef AS_RF_BYPASS_EN
    for (int k = 0; k < NR_WR; k++)
      if (we[k] && wclr[k] && waddr[k] == a && !(iss && iss_addr == a)) v = 1'b0;
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle();
    we = '0; wclr = '0; iss = 1'b0; flush = 1'b0;
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] c,
                       input logic is, input logic [4:0] ia, input logic fl);
    we = w; waddr[0] = a0; waddr[1] = a1; wdata[0] = d0; wdata[1] = d1;
    wclr = c; iss = is; iss_addr = ia; flush = fl;
  endtask

  initial begin
    logic [31:0] same_rd;
    logic same_rb;
    idle();
    waddr = '0; wdata = '0; iss_addr = '0; raddr = '0;
    #1 rst = 1'b1;
    model_reset();
    raddr[0] = 5'd5; raddr[1] = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata0", rdata[0], 32'h0);
    check("reset_rdata1", rdata[1], 32'h0);
    check("reset_rbusy", {30'h0, rbusy}, 32'h0);
    check("reset_busy", busy, 32'h0);
    check("reset_werr", {31'h0, werr}, 32'h0);
    @(negedge clk) rst = 1'b0;
    tick();

    raddr[0] = 5'd7;
    drive(2'b01, 5'd7, 5'd0, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    #1;
`ifdef AS_RF_BYPASS_EN
    same_rd = 32'hDEAD_BEEF;
`else
    same_rd = 32'h0;
`endif
    check("x7_same_cycle", rdata[0], same_rd);
    tick();
    idle();
    #1 check("x7_next_cycle", rdata[0], 32'hDEAD_BEEF);

    raddr[0] = 5'd13;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd13, 1'b0);
    tick();
    idle();
    #1 check("x13_busy", {31'h0, rbusy[0]}, 32'h1);
    drive(2'b01, 5'd13, 5'd0, 32'h77, 32'h0, 2'b01, 1'b0, 5'd0, 1'b0);
    #1;
`ifdef AS_RF_BYPASS_EN
    same_rb = 1'b0;
`else
    same_rb = 1'b1;
`endif
    check("x13_clr_same_cycle", {31'h0, rbusy[0]}, {31'h0, same_rb});
    tick();
    idle();
    #1 check("x13_clr_next", {31'h0, rbusy[0]}, 32'h0);

    tbl[0] = '{2'b01, 5'd21, 5'd0, 32'hCAFE_F00D, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd21, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[2] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd9, 1'b0, 5'd9, 32'h0, 1'b1, 32'h0000_0200, 1'b0};
    tbl[3] = '{2'b01, 5'd9, 5'd0, 32'h55, 32'h0, 2'b01, 1'b1, 5'd9, 1'b0, 5'd9, 32'h55, 1'b1, 32'h0000_0200, 1'b0};
    tbl[4] = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h66, 2'b10, 1'b0, 5'd0, 1'b0, 5'd9, 32'h66, 1'b0, 32'h0, 1'b0};
    tbl[5] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd10, 1'b0, 5'd10, 32'h0, 1'b1, 32'h0000_0400, 1'b0};
    tbl[6] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd4, 1'b1, 5'd4, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[7] = '{2'b11, 5'd3, 5'd3, 32'h11, 32'h22, 2'b00, 1'b0, 5'd0, 1'b0, 5'd3, 32'h22, 1'b0, 32'h0, 1'b1};
    tbl[8] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      raddr[0] = tbl[i].ra;
      drive(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1, tbl[i].wclr, tbl[i].iss, tbl[i].ia, tbl[i].fl);
      tick();
      idle();
      #1;
      check($sformatf("tbl%0d_rdata", i), rdata[0], tbl[i].e_rd);
      check($sformatf("tbl%0d_rbusy", i), {31'h0, rbusy[0]}, {31'h0, tbl[i].e_rb});
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_werr", i), {31'h0, werr}, {31'h0, tbl[i].e_werr});
    end

    raddr[0] = 5'd12;
    drive(2'b01, 5'd12, 5'd0, 32'hAA, 32'h0, 2'b00, 1'b1, 5'd12, 1'b0);
    tick();
    idle();
    #1;
    check("x12_written", rdata[0], 32'hAA);
    check("x12_busy", busy, 32'h0000_1000);
    drive(2'b01, 5'd12, 5'd0, 32'hBB, 32'h0, 2'b00, 1'b1, 5'd12, 1'b0);
    #1;
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    check("midrst_x12", rdata[0], 32'h0);
    check("midrst_busy", busy, 32'h0);
    check("midrst_werr", {31'h0, werr}, 32'h0);
    @(negedge clk) rst = 1'b0;
    tick();

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NR_WR; k++) begin
        we[k] = 1'($urandom);
        wclr[k] = 1'($urandom);
        waddr[k] = 5'($urandom_range(0, 7));
        wdata[k] = $urandom;
      end
      for (int j = 0; j < NR_RD; j++) raddr[j] = 5'($urandom_range(0, 7));
      iss = 1'($urandom);
      iss_addr = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 7) == 0;
      #1;
      for (int j = 0; j < NR_RD; j++) begin
        check($sformatf("rnd%0d_rdata%0d", n, j), rdata[j], exp_rdata(raddr[j]));
        check($sformatf("rnd%0d_rbusy%0d", n, j), {31'h0, rbusy[j]}, {31'h0, exp_rbusy(raddr[j])});
      end
      check($sformatf("rnd%0d_busy", n), busy, exp_busy_vec());
      check($sformatf("rnd%0d_werr", n), {31'h0, werr}, {31'h0, m_werr});
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
